// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result staging block.
// Holds the ALU opcode map, the beat FSM state encoding, the datapath width and the
// packed layout of one buffered result {opcode, Zlow, Zhigh}.
package alu_result_stage_pkg;

   localparam int unsigned DATA_W = 32;

   // ALU opcode map (same encoding as the ALU)
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;

   typedef enum logic {
      BEAT_LO = 1'b0,
      BEAT_HI = 1'b1
   } beat_state_t;

   typedef struct packed {
      logic [4:0]        opcode;
      logic [DATA_W-1:0] zlow;
      logic [DATA_W-1:0] zhigh;
   } result_t;

   localparam int unsigned RESULT_W = $bits(result_t);

   // Multiply/divide produce a 64-bit {HI,LO} result and need two bus beats.
   function automatic logic is_two_beat(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_result_stage_result_fifo.sv
// Result FIFO: DEPTH entries of packed {opcode, Zlow, Zhigh}.
// Ports:
//   clock, clear       rising-edge clock, asynchronous active-high reset
//   push, wr_data      write request and entry; ignored while full
//   pop                remove head entry; ignored while empty
//   rd_data            head entry (combinational read of registered storage)
//   full               registered full flag
//   empty              no entries held
module alu_result_stage_result_fifo
   import alu_result_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                push,
   input  logic [RESULT_W-1:0] wr_data,
   input  logic                pop,
   output logic [RESULT_W-1:0] rd_data,
   output logic                full,
   output logic                empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [RESULT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full_q;
   logic                push_ok, pop_ok;

   // Full blocks a push even when a pop happens the same cycle.
   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty;
   assign empty   = (count_q == '0);
   assign full    = full_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result staging: buffers ALU results and emits them as 32-bit bus beats.
// Multiply/divide results go out as LO then HI; all others as a single Z beat.
// Ports:
//   clock, clear            rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready      result handshake (in_ready is registered !full)
//   opcode, Zlow, Zhigh     ALU result and its opcode
//   out_valid, out_ready    beat handshake
//   out_data, out_hi        beat payload, 1 = HI word
//   out_last                final beat of the head result
//   out_zero, out_neg       head result flags, constant across its beats
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  opcode,
   input  logic [31:0] Zlow,
   input  logic [31:0] Zhigh,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_hi,
   output logic        out_last,
   output logic        out_zero,
   output logic        out_neg
);

   result_t             wr_entry, head;
   logic [RESULT_W-1:0] head_bits;
   logic                full, empty, pop, two_beat;
   beat_state_t         state_q, state_d;

   assign wr_entry = '{opcode: opcode, zlow: Zlow, zhigh: Zhigh};
   assign head     = result_t'(head_bits);
   assign in_ready = !full;

   alu_result_stage_result_fifo #(
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clock   (clock),
      .clear   (clear),
      .push    (in_valid),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head_bits),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= BEAT_LO;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      two_beat  = is_two_beat(head.opcode);
      out_valid = !empty;
      out_data  = '0;
      out_hi    = 1'b0;
      out_last  = 1'b0;
      out_zero  = 1'b0;
      out_neg   = 1'b0;
      if (!empty) begin
         // Two-beat results are judged on the full 64-bit {HI,LO} value.
         out_zero = two_beat ? ({head.zhigh, head.zlow} == 64'd0) : (head.zlow == '0);
         out_neg  = two_beat ? head.zhigh[31] : head.zlow[31];
         unique case (state_q)
            BEAT_LO: begin
               out_data = head.zlow;
               out_last = !two_beat;
               if (out_ready) begin
                  if (two_beat) state_d = BEAT_HI;
                  else          pop     = 1'b1;
               end
            end
            BEAT_HI: begin
               out_data = head.zhigh;
               out_hi   = 1'b1;
               out_last = 1'b1;
               if (out_ready) begin
                  pop     = 1'b1;
                  state_d = BEAT_LO;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Result staging block directly downstream of the ALU. Captures each completed ALU result (Zlow, Zhigh plus its opcode) into a small FIFO and presents it to the datapath bus as a sequence of 32-bit beats. Multiply/divide results go out as two beats (LO then HI); all other opcodes go out as one beat (Z). Zero/negative flags are produced per result for branch evaluation downstream.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept a result; registered, equals !full.
- opcode  in  5  ALU opcode of the result (same encoding as the ALU).
- Zlow  in  32  ALU low result word.
- Zhigh  in  32  ALU high result word; meaningful only for Multiply/Division.
- out_valid  out  1  a beat is presented.
- out_ready  in  1  bus accepts the presented beat.
- out_data  out  32  beat payload.
- out_hi  out  1  0 = Z/LO word, 1 = HI word.
- out_last  out  1  final beat of the current result.
- out_zero  out  1  head result is zero (32-bit for single-beat, 64-bit {Zhigh,Zlow} for two-beat).
- out_neg  out  1  head result sign: Zlow[31] single-beat, Zhigh[31] two-beat.

## Operation
- Push: in_valid && in_ready at a rising edge writes {opcode, Zlow, Zhigh} at write pointer; count+1.
- in_valid while !in_ready: input ignored, no state change; upstream holds data.
- Two-beat opcodes: Multiply 5'b01111, Division 5'b10000. All other opcodes single-beat.
- Beat FSM, states BEAT_LO, BEAT_HI:
  - BEAT_LO: out_data = head Zlow, out_hi=0, out_last = !two_beat(head).
  - BEAT_LO, accept (out_valid && out_ready): two-beat -> BEAT_HI; single-beat -> pop, stay BEAT_LO.
  - BEAT_HI: out_data = head Zhigh, out_hi=1, out_last=1; accept -> pop, BEAT_LO.
- out_valid = !empty. When empty, out_data, out_hi, out_last, out_zero, out_neg are 0.
- Flags computed from head entry; constant across both beats of one result.
- Simultaneous push and pop in one cycle: both happen, count unchanged. When full, push is blocked even if a pop occurs that cycle (in_ready is registered !full, no combinational path from out_ready).
- Pointers wrap modulo DEPTH; count range 0..DEPTH.

## Timing
- clear asserted (any time, including mid two-beat): pointers=0, count=0, FSM=BEAT_LO, in_ready=1 after release... in_ready=0 while clear high is NOT required: in_ready reset value 1; out_valid and all out_* are 0. Buffered results are discarded.
- Latency: result pushed at edge N appears with out_valid=1 in cycle after N (registered storage, combinational head read). Minimum one cycle, independent of FIFO occupancy when empty.
- Throughput: one single-beat result per cycle; a two-beat result occupies output for two accepted beats.
- out_valid, out_data, out_hi, out_last stable while out_valid && !out_ready.
- in_ready updates the cycle after count changes.

## Structure
- Shared package: opcode constants (all 20 ALU opcodes, notably Multiply/Division), beat-state encoding, width constant 32.
- Sub-module result_fifo: DEPTH×69-bit storage, pointers, count, full/empty; alu_result_stage adds beat FSM, flag logic, output mux.

## Test plan
- Single add: push opcode 5'b00011, Zlow=32'h0000_0005, out_ready=1 -> next cycle one beat, out_data=5, out_hi=0, out_last=1, out_zero=0, out_neg=0; then empty.
- Multiply: push 5'b01111, Zlow=32'h89AB_CDEF, Zhigh=32'hFFFF_FFFE -> beats 89ABCDEF (out_hi=0, out_last=0) then FFFFFFFE (out_hi=1, out_last=1); out_neg=1 both beats.
- Backpressure: DEPTH=2, out_ready=0, push three results -> third refused (in_ready=0 after second); outputs held stable; release out_ready -> first two drain in order, then third accepted.
- Zero flag: Division Zlow=0, Zhigh=0 -> out_zero=1; Subtraction Zlow=0 with Zhigh=32'h1234 -> out_zero=1 (Zhigh ignored).
- Simultaneous push/pop at count=1 over 50 cycles of continuous single-beat traffic -> count stays 1, order preserved, pointers wrap correctly.
- clear during BEAT_HI of a multiply -> out_valid=0 immediately, in_ready=1, next pushed Not result emerges as single beat with out_hi=0.
